// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared definitions for the reaction-timer round controller: state encoding,
// LFSR constants and parameter defaults.
package reaction_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_MEASURE = 3'd3,
    ST_SHOW    = 3'd4,
    ST_EARLY   = 3'd5
  } state_e;

  localparam logic [7:0]  LFSR_SEED     = 8'h01;
  // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
  localparam logic [7:0]  LFSR_TAPS     = 8'hB8;

  localparam int          MS_PERIOD_DEF = 50000;
  localparam logic [13:0] MAX_MS_DEF    = 14'd9999;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_timer_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; a nonzero seed keeps it out of the all-zero
// lock-up state.
module lfsr8
  import reaction_timer_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] q
);

  logic [7:0] q_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= LFSR_SEED;
    else          q_q <= lfsr_next(q_q);
  end

  assign q = q_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer round controller: random delay via delay_counter, stimulus LED,
// millisecond response measurement and false-start detection.
module reaction_timer_ctrl
  import reaction_timer_ctrl_pkg::*;
#(
  parameter int          MS_PERIOD = MS_PERIOD_DEF,
  parameter logic [7:0]  MIN_DELAY = 8'd20,
  parameter logic [13:0] MAX_MS    = MAX_MS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic        react,
  input  logic        timer_done,
  output logic        timer_start,
  output logic        timer_enable,
  output logic [7:0]  timer_delay,
  output logic        led,
  output logic [13:0] result,
  output logic        result_valid,
  output logic        early
);

  localparam int              SUBW    = (MS_PERIOD > 1) ? $clog2(MS_PERIOD) : 1;
  localparam logic [SUBW-1:0] SUB_MAX = SUBW'(MS_PERIOD - 1);

  state_e          state_q, state_d;
  logic            go_q, react_q;
  logic [7:0]      delay_q, delay_d;
  logic [13:0]     result_q, result_d;
  logic [13:0]     ms_q, ms_d;
  logic [SUBW-1:0] sub_q, sub_d;
  logic [7:0]      lfsr;
  logic            go_rise, react_rise, go_accept;

  lfsr8 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (lfsr)
  );

  assign go_rise    = go & ~go_q;
  assign react_rise = react & ~react_q;
  assign go_accept  = go_rise &&
                      (state_q == ST_IDLE || state_q == ST_SHOW || state_q == ST_EARLY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      go_q     <= 1'b0;
      react_q  <= 1'b0;
      delay_q  <= '0;
      result_q <= '0;
      ms_q     <= '0;
      sub_q    <= '0;
    end else begin
      state_q  <= state_d;
      go_q     <= go;
      react_q  <= react;
      delay_q  <= delay_d;
      result_q <= result_d;
      ms_q     <= ms_d;
      sub_q    <= sub_d;
    end
  end

  // A false start wins over a done arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (go_rise) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_WAIT;
      ST_WAIT: begin
        if (react_rise)      state_d = ST_EARLY;
        else if (timer_done) state_d = ST_MEASURE;
      end
      ST_MEASURE: if (react_rise) state_d = ST_SHOW;
      ST_SHOW,
      ST_EARLY:   if (go_rise) state_d = ST_LOAD;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Delay uses the LFSR value before this edge's update; the mask keeps the
  // sum inside MIN_DELAY..MIN_DELAY+127.
  always_comb begin
    delay_d  = delay_q;
    result_d = result_q;
    ms_d     = ms_q;
    sub_d    = sub_q;
    if (go_accept)
      delay_d = MIN_DELAY + (lfsr & 8'h7F);
    if (state_q == ST_WAIT && !react_rise && timer_done) begin
      ms_d  = '0;
      sub_d = '0;
    end else if (state_q == ST_MEASURE) begin
      if (react_rise)
        result_d = ms_q;
      if (sub_q == SUB_MAX) begin
        sub_d = '0;
        if (ms_q < MAX_MS) ms_d = ms_q + 14'd1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  always_comb begin
    timer_start  = (state_q == ST_LOAD);
    timer_enable = (state_q == ST_WAIT);
    led          = (state_q == ST_MEASURE);
    result_valid = (state_q == ST_SHOW);
    early        = (state_q == ST_EARLY);
  end

  assign timer_delay = delay_q;
  assign result      = result_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed + randomized bench for reaction_timer_ctrl with a behavioural
// delay_counter and reference LFSR.
module tb_reaction_timer_ctrl;

  localparam int          MS   = 4;
  localparam int          BP   = 5;
  localparam int          MIND = 20;
  localparam logic [13:0] MAXV = 14'd9999;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic        react = 1'b0;
  logic        timer_done;
  logic        timer_start, timer_enable, led, result_valid, early;
  logic [7:0]  timer_delay;
  logic [13:0] result;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reaction_timer_ctrl #(.MS_PERIOD(MS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .go           (go),
    .react        (react),
    .timer_done   (timer_done),
    .timer_start  (timer_start),
    .timer_enable (timer_enable),
    .timer_delay  (timer_delay),
    .led          (led),
    .result       (result),
    .result_valid (result_valid),
    .early        (early)
  );

  // delay_counter stand-in: done after delay*BP enabled cycles, cleared by start
  // or by losing enable.
  int   dc_cnt;
  logic dc_done;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dc_cnt <= 0; dc_done <= 1'b0;
    end else if (timer_start || !timer_enable) begin
      dc_cnt <= 0; dc_done <= 1'b0;
    end else if (dc_cnt >= int'(timer_delay) * BP - 1) begin
      dc_done <= 1'b1;
    end else begin
      dc_cnt <= dc_cnt + 1;
    end
  end
  assign timer_done = dc_done;

  // Reference LFSR: polynomial x^8+x^6+x^5+x^4+1, seed 1, one step per clock.
  logic [7:0] lm;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) lm <= 8'h01;
    else          lm <= {lm[6:0], lm[7] ^ lm[5] ^ lm[4] ^ lm[3]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_led();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (led) begin ok = 1; break; end
      step();
    end
    chk("led_rise_timeout", 32'(ok), 32'd1);
  endtask

  function automatic int exp_ms(input int n);
    return (n / MS > int'(MAXV)) ? int'(MAXV) : n / MS;
  endfunction

  // Starts a round from IDLE/SHOW/EARLY, reacts n cycles after the LED lights.
  task automatic do_round(input int n);
    int d;
    d = MIND + int'(lm & 8'h7F);
    go = 1'b1; step(); go = 1'b0;
    chk("start_pulse", 32'(timer_start), 32'd1);
    chk("delay_model", 32'(timer_delay), 32'(d));
    chk("delay_range", 32'(timer_delay >= 8'd20 && timer_delay <= 8'd147), 32'd1);
    step();
    chk("start_one_cycle", 32'(timer_start), 32'd0);
    chk("enable_on", 32'(timer_enable), 32'd1);
    wait_led();
    step(n);
    react = 1'b1; step();
    chk("result", 32'(result), 32'(exp_ms(n)));
    chk("result_valid", 32'(result_valid), 32'd1);
    chk("led_off", 32'(led), 32'd0);
    react = 1'b0; step();
  endtask

  initial begin
    int cnt;
    int held_res;

    step(3);
    chk("rst_start", 32'(timer_start), 32'd0);
    chk("rst_enable", 32'(timer_enable), 32'd0);
    chk("rst_delay", 32'(timer_delay), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_early", 32'(early), 32'd0);

    // go on the first edge after release: seed 1 -> delay 21
    reset_n = 1'b1;
    do_round(41);
    chk("first_delay", 32'(timer_delay), 32'd21);
    chk("first_result", 32'(result), 32'd10);

    // tick coincidence boundaries: 43 edges -> pre-increment 10, 44 -> 11
    do_round(43);
    do_round(44);
    do_round(0);

    // false start mid-WAIT
    held_res = int'(result);
    go = 1'b1; step(); go = 1'b0;
    step(4);
    react = 1'b1; step();
    chk("early_flag", 32'(early), 32'd1);
    chk("early_enable_off", 32'(timer_enable), 32'd0);
    chk("early_result_hold", 32'(result), 32'(held_res));
    react = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin step(); if (led) cnt++; end
    chk("early_no_led", 32'(cnt), 32'd0);
    chk("early_stays", 32'(early), 32'd1);

    // react in the same cycle timer_done is seen
    go = 1'b1; step(); go = 1'b0; step();
    cnt = 0;
    for (int i = 0; i < 2000 && !timer_done; i++) begin step(); cnt++; end
    chk("done_seen", 32'(timer_done), 32'd1);
    react = 1'b1; step();
    chk("tie_early", 32'(early), 32'd1);
    chk("tie_led", 32'(led), 32'd0);
    chk("tie_enable_off", 32'(timer_enable), 32'd0);
    react = 1'b0; step();

    do_round(9);

    // go held for 100 cycles in SHOW starts exactly one round
    cnt = 0;
    go = 1'b1;
    for (int i = 0; i < 100; i++) begin step(); if (timer_start) cnt++; end
    go = 1'b0;
    chk("held_go_one_round", 32'(cnt), 32'd1);
    wait_led();
    step(7);
    react = 1'b1; step();
    chk("held_go_result", 32'(result), 32'd1);
    react = 1'b0; step();

    for (int r = 0; r < 10; r++) do_round(int'($urandom_range(0, 80)));

    // react held from before the round: saturation of the ms count
    held_res = int'(result);
    react = 1'b1; step();
    go = 1'b1; step(); go = 1'b0;
    wait_led();
    step(41000);
    chk("sat_still_measuring", 32'(led), 32'd1);
    chk("sat_result_hold", 32'(result), 32'(held_res));
    react = 1'b0; step();
    react = 1'b1; step();
    chk("sat_result", 32'(result), 32'(MAXV));
    chk("sat_valid", 32'(result_valid), 32'd1);
    react = 1'b0; step();

    // asynchronous reset in the middle of MEASURE
    do_round(12);
    go = 1'b1; step(); go = 1'b0;
    wait_led();
    step(20);
    reset_n = 1'b0;
    #1;
    chk("arst_led", 32'(led), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_valid", 32'(result_valid), 32'd0);
    chk("arst_delay", 32'(timer_delay), 32'd0);
    chk("arst_enable", 32'(timer_enable), 32'd0);
    chk("arst_start", 32'(timer_start), 32'd0);
    chk("arst_early", 32'(early), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); if (led || timer_start || timer_enable) cnt++; end
    chk("post_rst_idle", 32'(cnt), 32'd0);
    do_round(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
